// File: rtl/memory_map_responder_if.sv
// Data-memory bus between the single-cycle core (master) and the memory map
// responder (slave). Load data and the bus error flag are combinational from
// the slave, so a load completes in the same cycle it is issued.
interface memory_map_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_write;
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] data_o_map;
  logic                  bus_err;

  modport master (
    output mem_write, mem_read, addr, wdata,
    input  data_o_map, bus_err
  );

  modport slave (
    input  mem_write, mem_read, addr, wdata,
    output data_o_map, bus_err
  );
endinterface

// File: rtl/memory_map_responder.sv
// Memory map responder for the core's data-memory port.
// Decodes word addresses into a data RAM and a small I/O page (GPIO and an
// optional compare timer). Loads are combinational, stores commit on clk.
// Build option: define MMAP_TIMER_EN to include the CNT/CMP/STAT/CTRL timer;
// without it those offsets still decode (no bus_err) but read 0 and ignore
// writes, and timer_irq is tied low.
module memory_map_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = 32'h1001_0000,
  parameter int                    RAM_WORDS  = 64,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'h1001_0400,
  parameter int                    GPIO_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_map_responder_if.slave bus,
  input  logic [GPIO_W-1:0]     gpio_in,
  output logic [GPIO_W-1:0]     gpio_out,
  output logic                  timer_irq
);

  localparam int                    IDX_W     = $clog2(RAM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] RAM_BYTES = ADDR_WIDTH'(4 * RAM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] IO_BYTES  = ADDR_WIDTH'(32);

  // Word slots inside the I/O page; slots 6 and 7 are unmapped
  localparam logic [2:0] REG_GPIO_OUT = 3'd0;
  localparam logic [2:0] REG_GPIO_IN  = 3'd1;
  localparam logic [2:0] REG_CTRL     = 3'd5;
`ifdef MMAP_TIMER_EN
  localparam logic [2:0] REG_CNT      = 3'd2;
  localparam logic [2:0] REG_CMP      = 3'd3;
  localparam logic [2:0] REG_STAT     = 3'd4;
`endif

  logic [ADDR_WIDTH-1:0] ram_off;
  logic [ADDR_WIDTH-1:0] io_off;
  logic                  ram_hit;
  logic                  io_hit;
  logic                  io_mapped;
  logic [IDX_W-1:0]      ram_idx;
  logic [2:0]            io_reg;
  logic                  ram_we;
  logic                  io_we;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
  logic [GPIO_W-1:0]     gpio_meta;
  logic [GPIO_W-1:0]     gpio_sync;

  // Offsets are unsigned, so an address below a base wraps to a huge
  // offset and fails the range check without a separate lower-bound compare.
  assign ram_off   = bus.addr - RAM_BASE;
  assign io_off    = bus.addr - IO_BASE;
  assign ram_hit   = ram_off < RAM_BYTES;
  assign io_hit    = io_off < IO_BYTES;
  assign io_reg    = io_off[4:2];
  assign io_mapped = io_hit && (io_reg <= REG_CTRL);
  assign ram_idx   = bus.addr[IDX_W+1:2];

  assign ram_we = bus.mem_write & ram_hit;
  assign io_we  = bus.mem_write & io_mapped & ~ram_hit;

  assign bus.bus_err    = (bus.mem_read | bus.mem_write) & ~(ram_hit | io_mapped);
  assign bus.data_o_map = rdata;

  // Data RAM store port; contents survive reset, but a store coinciding
  // with reset is dropped
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      ram[ram_idx] <= bus.wdata;
    end
  end

  // GPIO output register and two-flop synchroniser for the input pins
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out  <= '0;
      gpio_meta <= '0;
      gpio_sync <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
      if (io_we && io_reg == REG_GPIO_OUT) begin
        gpio_out <= bus.wdata[GPIO_W-1:0];
      end
    end
  end

`ifdef MMAP_TIMER_EN
  logic [DATA_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] cmp;
  logic [2:0]            ctrl;
  logic                  stat_match;
  logic                  match;

  // A match needs the timer running; the compare always uses the CMP value
  // held before any same-cycle CMP write
  assign match = ctrl[0] && (cnt == cmp);

  // Compare timer: counter, compare register, sticky match flag, control
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      cmp        <= '1;
      ctrl       <= '0;
      stat_match <= 1'b0;
    end else begin
      if (ctrl[0]) begin
        if (match && ctrl[1]) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + DATA_WIDTH'(1);
        end
      end
      if (io_we && io_reg == REG_CMP) begin
        cmp <= bus.wdata;
      end
      if (io_we && io_reg == REG_CTRL) begin
        ctrl <= bus.wdata[2:0];
      end
      if (match) begin
        stat_match <= 1'b1;
      end else if (io_we && io_reg == REG_STAT && bus.wdata[0]) begin
        stat_match <= 1'b0;
      end
    end
  end

  assign timer_irq = stat_match & ctrl[2];
`else
  assign timer_irq = 1'b0;
`endif

  // Load data mux: zero unless a mapped location is being read
  always_comb begin
    rdata = '0;
    if (bus.mem_read) begin
      if (ram_hit) begin
        rdata = ram[ram_idx];
      end else if (io_mapped) begin
        case (io_reg)
          REG_GPIO_OUT: rdata = DATA_WIDTH'(gpio_out);
          REG_GPIO_IN:  rdata = DATA_WIDTH'(gpio_sync);
`ifdef MMAP_TIMER_EN
          REG_CNT:      rdata = cnt;
          REG_CMP:      rdata = cmp;
          REG_STAT:     rdata = DATA_WIDTH'(stat_match);
          REG_CTRL:     rdata = DATA_WIDTH'(ctrl);
`endif
          default:      rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_map_responder.sv
// Testbench for memory_map_responder: random RAM traffic against an array
// model, decode boundaries, GPIO, reset behaviour and (when MMAP_TIMER_EN is
// defined) the compare timer, predicted arithmetically from elapsed cycles.
module tb_memory_map_responder;
  localparam int          DW        = 32;
  localparam int          AW        = 32;
  localparam int          RAM_WORDS = 64;
  localparam int          GPIO_W    = 8;
  localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] IO_BASE   = 32'h1001_0400;
  localparam logic [31:0] A_GPO     = IO_BASE + 32'h00;
  localparam logic [31:0] A_GPI     = IO_BASE + 32'h04;
  localparam logic [31:0] A_CNT     = IO_BASE + 32'h08;
  localparam logic [31:0] A_CMP     = IO_BASE + 32'h0C;
  localparam logic [31:0] A_STAT    = IO_BASE + 32'h10;
  localparam logic [31:0] A_CTRL    = IO_BASE + 32'h14;

  logic              clk = 1'b0;
  logic              rst;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic              timer_irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram_model [RAM_WORDS];

  memory_map_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  memory_map_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_BASE(RAM_BASE),
    .RAM_WORDS(RAM_WORDS), .IO_BASE(IO_BASE), .GPIO_W(GPIO_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.addr      = a;
    bus.wdata     = d;
    tick();
    bus.mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    bus.mem_read = 1'b1;
    bus.addr     = a;
    #1;
    d = bus.data_o_map;
    e = bus.bus_err;
    bus.mem_read = 1'b0;
  endtask

  task automatic do_reset;
    bus_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic        e;
    rst = 1'b1;
    gpio_in = '0;
    bus_idle();
    repeat (3) tick();
    rst = 1'b0;
    n_checks++; if (gpio_out !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_gpio_out got %h exp 00", gpio_out); end
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq got %b exp 0", timer_irq); end
    bus_read(A_GPI, d, e);
    n_checks++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gpio_in got %h/%b exp 0/0", d, e); end
`ifdef MMAP_TIMER_EN
    bus_read(A_CNT, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_cnt got %h exp 0", d); end
    bus_read(A_CMP, d, e);
    n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL reset_cmp got %h exp ffffffff", d); end
    bus_read(A_STAT, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_stat got %h exp 0", d); end
    bus_read(A_CTRL, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ctrl got %h exp 0", d); end
`endif
  endtask

  task automatic test_ram;
    logic [31:0] d;
    logic        e;
    bus_write(RAM_BASE, 32'hDEAD_BEEF);
    ram_model[0] = 32'hDEAD_BEEF;
    bus_read(RAM_BASE, d, e);
    n_checks++; if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin n_fail++; $display("[TB] FAIL ram_word0 got %h/%b exp deadbeef/0", d, e); end
    bus_write(RAM_BASE + 32'hFC, 32'h0BAD_F00D);
    ram_model[RAM_WORDS-1] = 32'h0BAD_F00D;
    bus_read(RAM_BASE + 32'hFC, d, e);
    n_checks++; if (d !== 32'h0BAD_F00D || e !== 1'b0) begin n_fail++; $display("[TB] FAIL ram_last got %h/%b exp 0badf00d/0", d, e); end
    bus_read(RAM_BASE, d, e);
    n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL ram_word0_kept got %h exp deadbeef", d); end
    // Fill every word so later random reads always have a known value
    for (int i = 0; i < RAM_WORDS; i++) begin
      ram_model[i] = $urandom;
      bus_write(RAM_BASE + 32'(i * 4), ram_model[i]);
    end
    for (int i = 0; i < 80; i++) begin
      int          idx = $urandom_range(0, RAM_WORDS - 1);
      logic [31:0] a   = RAM_BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      logic [31:0] v   = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          bus_write(a, v);
          ram_model[idx] = v;
        end
        1: begin
          bus_read(a, d, e);
          n_checks++; if (d !== ram_model[idx] || e !== 1'b0) begin n_fail++; $display("[TB] FAIL ram_rand_read idx=%0d got %h/%b exp %h/0", idx, d, e, ram_model[idx]); end
        end
        default: begin
          bus.mem_read  = 1'b1;
          bus.mem_write = 1'b1;
          bus.addr      = a;
          bus.wdata     = v;
          #1;
          n_checks++; if (bus.data_o_map !== ram_model[idx]) begin n_fail++; $display("[TB] FAIL ram_rw_old idx=%0d got %h exp %h", idx, bus.data_o_map, ram_model[idx]); end
          tick();
          bus_idle();
          ram_model[idx] = v;
        end
      endcase
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] d;
    logic        e;
    logic [31:0] bad [6];
    bad[0] = RAM_BASE + 32'h100;
    bad[1] = RAM_BASE - 32'h4;
    bad[2] = IO_BASE + 32'h18;
    bad[3] = IO_BASE + 32'h1C;
    bad[4] = IO_BASE + 32'h20;
    bad[5] = 32'h0000_0000;
    for (int i = 0; i < 6; i++) begin
      bus_read(bad[i], d, e);
      n_checks++; if (d !== 32'h0 || e !== 1'b1) begin n_fail++; $display("[TB] FAIL unmapped_read a=%h got %h/%b exp 0/1", bad[i], d, e); end
    end
    bus.mem_write = 1'b1;
    bus.addr      = RAM_BASE + 32'h100;
    bus.wdata     = 32'h1234;
    #1;
    n_checks++; if (bus.bus_err !== 1'b1) begin n_fail++; $display("[TB] FAIL unmapped_write_err got %b exp 1", bus.bus_err); end
    tick();
    bus_idle();
    bus_read(RAM_BASE, d, e);
    n_checks++; if (d !== ram_model[0]) begin n_fail++; $display("[TB] FAIL unmapped_write_ram got %h exp %h", d, ram_model[0]); end
    bus_read(RAM_BASE + 32'hFC, d, e);
    n_checks++; if (d !== ram_model[RAM_WORDS-1]) begin n_fail++; $display("[TB] FAIL unmapped_write_ram_top got %h exp %h", d, ram_model[RAM_WORDS-1]); end
    bus.addr = RAM_BASE;
    #1;
    n_checks++; if (bus.data_o_map !== 32'h0 || bus.bus_err !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_bus got %h/%b exp 0/0", bus.data_o_map, bus.bus_err); end
  endtask

  task automatic test_gpio;
    logic [31:0] d;
    logic        e;
    logic [7:0]  prev;
    bus_write(A_GPO, 32'h0000_00A5);
    n_checks++; if (gpio_out !== 8'hA5) begin n_fail++; $display("[TB] FAIL gpio_out got %h exp a5", gpio_out); end
    prev = gpio_in;
    gpio_in = 8'h3C;
    tick();
    bus_read(A_GPI, d, e);
    n_checks++; if (d !== 32'(prev)) begin n_fail++; $display("[TB] FAIL gpio_in_lag got %h exp %h", d, prev); end
    tick();
    tick();
    bus_read(A_GPI, d, e);
    n_checks++; if (d !== 32'h3C || e !== 1'b0) begin n_fail++; $display("[TB] FAIL gpio_in_sync got %h/%b exp 3c/0", d, e); end
    for (int i = 0; i < 6; i++) begin
      logic [31:0] v = $urandom;
      logic [7:0]  p = 8'($urandom);
      bus_write(A_GPO, v);
      gpio_in = p;
      n_checks++; if (gpio_out !== v[7:0]) begin n_fail++; $display("[TB] FAIL gpio_out_rand got %h exp %h", gpio_out, v[7:0]); end
      bus_read(A_GPO, d, e);
      n_checks++; if (d !== {24'h0, v[7:0]}) begin n_fail++; $display("[TB] FAIL gpio_out_read got %h exp %h", d, v[7:0]); end
      repeat (3) tick();
      bus_read(A_GPI, d, e);
      n_checks++; if (d !== {24'h0, p}) begin n_fail++; $display("[TB] FAIL gpio_in_rand got %h exp %h", d, p); end
    end
  endtask

`ifdef MMAP_TIMER_EN
  // Counter after k cycles of running from 0: k, or k mod (cmp+1) on reload
  task automatic test_timer_match(input logic reload);
    logic [31:0] d;
    logic        e;
    do_reset();
    bus_write(A_CMP, 32'd5);
    bus_write(A_CTRL, reload ? 32'h7 : 32'h5);
    bus.mem_read = 1'b1;
    bus.addr     = A_CNT;
    for (int k = 1; k <= 14; k++) begin
      logic [31:0] exp_cnt = reload ? 32'(k % 6) : 32'(k);
      tick();
      n_checks++; if (bus.data_o_map !== exp_cnt) begin n_fail++; $display("[TB] FAIL timer_cnt reload=%b k=%0d got %h exp %h", reload, k, bus.data_o_map, exp_cnt); end
      n_checks++; if (timer_irq !== (k >= 6)) begin n_fail++; $display("[TB] FAIL timer_irq reload=%b k=%0d got %b exp %b", reload, k, timer_irq, (k >= 6)); end
    end
    bus_idle();
    bus_read(A_STAT, d, e);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("[TB] FAIL timer_stat got %h exp 1", d); end
  endtask

  task automatic test_w1c_collision;
    do_reset();
    bus_write(A_CMP, 32'd3);
    bus_write(A_CTRL, 32'h5);
    repeat (3) tick();
    bus.mem_write = 1'b1;
    bus.mem_read  = 1'b1;
    bus.addr      = A_STAT;
    bus.wdata     = 32'h1;
    #1;
    n_checks++; if (bus.data_o_map !== 32'h0) begin n_fail++; $display("[TB] FAIL w1c_pre got %h exp 0", bus.data_o_map); end
    tick();
    n_checks++; if (bus.data_o_map !== 32'h1 || timer_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL w1c_set_wins got %h/%b exp 1/1", bus.data_o_map, timer_irq); end
    tick();
    n_checks++; if (bus.data_o_map !== 32'h0 || timer_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL w1c_clear got %h/%b exp 0/0", bus.data_o_map, timer_irq); end
    bus_idle();
  endtask
`else
  task automatic test_timer_absent;
    logic [31:0] d;
    logic        e;
    logic [31:0] offs [4];
    offs[0] = A_CNT;
    offs[1] = A_CMP;
    offs[2] = A_STAT;
    offs[3] = A_CTRL;
    for (int i = 0; i < 4; i++) begin
      bus_write(offs[i], $urandom | 32'h7);
      bus_read(offs[i], d, e);
      n_checks++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("[TB] FAIL notimer_read a=%h got %h/%b exp 0/0", offs[i], d, e); end
    end
    repeat (10) tick();
    n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL notimer_irq got %b exp 0", timer_irq); end
  endtask
`endif

  task automatic test_rst_mid;
    logic [31:0] d;
    logic        e;
    do_reset();
    bus_write(A_GPO, 32'h5A);
    gpio_in = 8'hFF;
`ifdef MMAP_TIMER_EN
    bus_write(A_CMP, 32'd1000);
    bus_write(A_CTRL, 32'h1);
    repeat (100) tick();
    bus_read(A_CNT, d, e);
    n_checks++; if (d !== 32'd100) begin n_fail++; $display("[TB] FAIL rst_mid_cnt_pre got %0d exp 100", d); end
`else
    repeat (5) tick();
`endif
    rst           = 1'b1;
    bus.mem_write = 1'b1;
    bus.addr      = RAM_BASE + 32'hC;
    bus.wdata     = ~ram_model[3];
    tick();
    rst = 1'b0;
    bus_idle();
    n_checks++; if (gpio_out !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_mid_gpio got %h exp 00", gpio_out); end
    bus_read(A_GPI, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mid_sync got %h exp 0", d); end
    bus_read(RAM_BASE + 32'hC, d, e);
    n_checks++; if (d !== ram_model[3]) begin n_fail++; $display("[TB] FAIL rst_mid_drop got %h exp %h", d, ram_model[3]); end
    bus_read(RAM_BASE, d, e);
    n_checks++; if (d !== ram_model[0]) begin n_fail++; $display("[TB] FAIL rst_mid_ram got %h exp %h", d, ram_model[0]); end
`ifdef MMAP_TIMER_EN
    bus_read(A_CNT, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mid_cnt got %h exp 0", d); end
    bus_read(A_CTRL, d, e);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mid_ctrl got %h exp 0", d); end
    bus_read(A_CMP, d, e);
    n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL rst_mid_cmp got %h exp ffffffff", d); end
`endif
  endtask

  // Test sequence
  initial begin
    $display("[TB] memory_map_responder test start");
    test_reset();
    test_ram();
    test_unmapped();
    test_gpio();
`ifdef MMAP_TIMER_EN
    test_timer_match(1'b0);
    test_timer_match(1'b1);
    test_w1c_collision();
`else
    test_timer_absent();
`endif
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
